param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/param_sync_fifo_if.sv | 39 +++
 rtl/fifo_mem.sv | 35 +++
 rtl/param_sync_fifo.sv | 132 +++++++++++++
 tb/tb_param_sync_fifo.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family.
// Holds the default word/pointer widths, the depth derivation and the
// status-flag bundle that every FIFO variant decodes from its occupancy count.
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEFAULT_ADDR_W = 3;

    // Number of entries addressed by a pointer of addr_w bits.
    function automatic int unsigned fifo_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    // Occupancy-derived status flags.
    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_flags_t;

endpackage

// File: rtl/param_sync_fifo_if.sv
// Handshake bundle between a FIFO user (master) and param_sync_fifo (slave).
// Signals:
//   wr_en, wr_data           write request and word
//   rd_en                    pop request
//   err_clr                  clear sticky error flags
//   rd_data                  read word
//   empty, full              occupancy extremes
//   almost_empty/full        threshold flags
//   count                    stored word count, 0..DEPTH
//   overflow, underflow      sticky error flags
interface param_sync_fifo_if #(
    parameter int unsigned DATA_W = fifo_pkg::DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = fifo_pkg::DEFAULT_ADDR_W
);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              err_clr;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  rd_data, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output rd_data, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_W register array.
// Synchronous write, asynchronous (combinational) read. Not reset: stale
// contents are never observable because occupancy is tracked by the controller.
// Ports:
//   clk      write clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write word
//   rd_addr  read address
//   rd_data  word at rd_addr
module fifo_mem import fifo_pkg::*; #(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock parameterised FIFO controller.
// Owns pointers, occupancy count, status flags, sticky error flags and the
// read-data register; storage lives in fifo_mem.
// FWFT=0: rd_data is registered on the edge a pop is accepted (1-cycle latency).
// FWFT=1: rd_data continuously presents the head word; rd_en pops it.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of param_sync_fifo_if (requests in, data/status out)
module param_sync_fifo import fifo_pkg::*; #(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned AF_LEVEL = fifo_depth(ADDR_W) - 1,
    parameter int unsigned AE_LEVEL = 1,
    parameter bit          FWFT     = 1'b0
) (
    input logic              clk,
    input logic              rst_n,
    param_sync_fifo_if.slave bus
);

    localparam int unsigned     DEPTH     = fifo_depth(ADDR_W);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W + 1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              rd_acc, wr_acc;
    logic [DATA_W-1:0] mem_rdata;
    fifo_flags_t       flags;

    // Flags are pure decodes of the registered count.
    always_comb begin
        flags              = '0;
        flags.empty        = (count_q == '0);
        flags.full         = (count_q == DEPTH_CNT);
        flags.almost_empty = (count_q <= AE_CNT);
        flags.almost_full  = (count_q >= AF_CNT);
    end

    // A write into a full FIFO is allowed only when a pop frees a slot the same cycle.
    always_comb begin
        rd_acc = bus.rd_en && !flags.empty;
        wr_acc = bus.wr_en && (!flags.full || rd_acc);
    end

    always_comb begin
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Sticky errors: a fresh error in the same cycle beats err_clr.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (bus.wr_en && !wr_acc) begin
            overflow_d = 1'b1;
        end
        if (bus.rd_en && !rd_acc) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.wr_data),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rdata)
    );

    if (FWFT) begin : g_fwft
        // Head word is undefined while empty; force zero so reset/empty reads are clean.
        assign bus.rd_data = flags.empty ? '0 : mem_rdata;
    end else begin : g_reg
        logic [DATA_W-1:0] rd_data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q <= '0;
            end else if (rd_acc) begin
                rd_data_q <= mem_rdata;
            end
        end

        assign bus.rd_data = rd_data_q;
    end

    assign bus.empty        = flags.empty;
    assign bus.full         = flags.full;
    assign bus.almost_empty = flags.almost_empty;
    assign bus.almost_full  = flags.almost_full;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: a registered-read instance (dut0)
// and a first-word-fall-through instance (dut1) driven with identical stimulus.
module tb_param_sync_fifo;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam int          DEPTH = 8;

    logic clk;
    logic rst_n;
    logic wr_en, rd_en, err_clr;
    logic [DW-1:0] wr_data;

    param_sync_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    param_sync_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    assign bus0.wr_en   = wr_en;
    assign bus0.wr_data = wr_data;
    assign bus0.rd_en   = rd_en;
    assign bus0.err_clr = err_clr;
    assign bus1.wr_en   = wr_en;
    assign bus1.wr_data = wr_data;
    assign bus1.rd_en   = rd_en;
    assign bus1.err_clr = err_clr;

    param_sync_fifo #(
        .DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(1'b0)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    param_sync_fifo #(
        .DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(1'b1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: words the model has accepted, oldest first.
    logic [DW-1:0] sb[$];
    int            m_count = 0;

    typedef struct {
        logic          wr;
        logic          rd;
        logic          clr;
        logic [DW-1:0] wdata;
        int            cnt;
        logic          full;
        logic          empty;
        logic          af;
        logic          ae;
        logic          ovf;
        logic          unf;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; inputs change 1ns after the active edge.
    task automatic cycle(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
        logic          m_rd, m_wr;
        logic [DW-1:0] popped;
        wr_en   = w;
        rd_en   = r;
        err_clr = c;
        wr_data = d;
        m_rd = r && (m_count != 0);
        m_wr = w && ((m_count != DEPTH) || m_rd);
        if (m_count != 0) chk("fwft head", 32'(bus1.rd_data), 32'(sb[0]));
        @(posedge clk);
        #1;
        if (m_rd) begin
            popped = sb.pop_front();
            chk("reg rd_data", 32'(bus0.rd_data), 32'(popped));
        end
        if (m_wr) sb.push_back(d);
        m_count = m_count + (m_wr ? 1 : 0) - (m_rd ? 1 : 0);
        chk("model count", 32'(bus0.count), 32'(m_count));
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        wr_data = '0;
    endtask

    function automatic vec_t mk(input logic w, input logic r, input logic c,
                                input logic [DW-1:0] d, input int cnt,
                                input logic ovf, input logic unf, input logic [DW-1:0] rdata);
        vec_t v;
        v.wr = w; v.rd = r; v.clr = c; v.wdata = d; v.cnt = cnt;
        v.full  = (cnt == DEPTH);
        v.empty = (cnt == 0);
        v.af    = (cnt >= 7);
        v.ae    = (cnt <= 1);
        v.ovf = ovf; v.unf = unf; v.rdata = rdata;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Fill, overflow, clear, drain, underflow, clear.
        for (int i = 0; i < 8; i++)
            vecs[i] = mk(1'b1, 1'b0, 1'b0, 8'(8'h11 * (i + 1)), i + 1, 1'b0, 1'b0, 8'h00);
        vecs[8] = mk(1'b1, 1'b0, 1'b0, 8'h99, 8, 1'b1, 1'b0, 8'h00);
        vecs[9] = mk(1'b0, 1'b0, 1'b1, 8'h00, 8, 1'b0, 1'b0, 8'h00);
        for (int j = 0; j < 8; j++)
            vecs[10 + j] = mk(1'b0, 1'b1, 1'b0, 8'h00, 7 - j, 1'b0, 1'b0, 8'(8'h11 * (j + 1)));
        vecs[18] = mk(1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 8'h88);
        vecs[19] = mk(1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 8'h88);

        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst count", 32'(bus0.count), 32'd0);
        chk("rst empty", 32'(bus0.empty), 32'd1);
        chk("rst full", 32'(bus0.full), 32'd0);
        chk("rst ae", 32'(bus0.almost_empty), 32'd1);
        chk("rst af", 32'(bus0.almost_full), 32'd0);
        chk("rst ovf", 32'(bus0.overflow), 32'd0);
        chk("rst unf", 32'(bus0.underflow), 32'd0);
        chk("rst rd_data0", 32'(bus0.rd_data), 32'd0);
        chk("rst rd_data1", 32'(bus1.rd_data), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            cycle(vecs[k].wr, vecs[k].rd, vecs[k].clr, vecs[k].wdata);
            chk($sformatf("v%0d count", k), 32'(bus0.count), 32'(vecs[k].cnt));
            chk($sformatf("v%0d full", k), 32'(bus0.full), 32'(vecs[k].full));
            chk($sformatf("v%0d empty", k), 32'(bus0.empty), 32'(vecs[k].empty));
            chk($sformatf("v%0d af", k), 32'(bus0.almost_full), 32'(vecs[k].af));
            chk($sformatf("v%0d ae", k), 32'(bus0.almost_empty), 32'(vecs[k].ae));
            chk($sformatf("v%0d ovf", k), 32'(bus0.overflow), 32'(vecs[k].ovf));
            chk($sformatf("v%0d unf", k), 32'(bus0.underflow), 32'(vecs[k].unf));
            chk($sformatf("v%0d rd_data", k), 32'(bus0.rd_data), 32'(vecs[k].rdata));
            chk($sformatf("v%0d count1", k), 32'(bus1.count), 32'(vecs[k].cnt));
        end

        // Full FIFO: rejected write with err_clr still sets overflow.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 1'b0, 8'(i));
        cycle(1'b1, 1'b0, 1'b1, 8'h77);
        chk("set beats clr", 32'(bus0.overflow), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        chk("ovf cleared", 32'(bus0.overflow), 32'd0);

        // Full FIFO: simultaneous read+write is accepted.
        cycle(1'b1, 1'b1, 1'b0, 8'hA5);
        chk("rw full count", 32'(bus0.count), 32'd8);
        chk("rw full ovf", 32'(bus0.overflow), 32'd0);
        chk("rw full full", 32'(bus0.full), 32'd1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        chk("a5 last", 32'(bus0.rd_data), 32'hA5);
        chk("a5 empty", 32'(bus0.empty), 32'd1);

        // Interleaved traffic across pointer wrap.
        for (int i = 0; i < 12; i++) cycle(1'b1, (i > 0), 1'b0, 8'(8'hC0 + i));
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        chk("wrap count", 32'(bus0.count), 32'd0);
        chk("wrap empty", 32'(bus0.empty), 32'd1);
        chk("wrap unf", 32'(bus0.underflow), 32'd0);

        // FWFT: head word visible the cycle after the write, no rd_en needed.
        cycle(1'b1, 1'b0, 1'b0, 8'h3C);
        chk("fwft 3c", 32'(bus1.rd_data), 32'h3C);
        chk("fwft not empty", 32'(bus1.empty), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        chk("fwft 3c hold", 32'(bus1.rd_data), 32'h3C);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        chk("fwft pop empty", 32'(bus1.empty), 32'd1);

        // Asynchronous reset with 5 words stored.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h50 + i));
        chk("pre-rst count", 32'(bus0.count), 32'd5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        sb.delete();
        m_count = 0;
        chk("async count", 32'(bus0.count), 32'd0);
        chk("async empty", 32'(bus0.empty), 32'd1);
        chk("async ae", 32'(bus0.almost_empty), 32'd1);
        chk("async af", 32'(bus0.almost_full), 32'd0);
        chk("async full", 32'(bus0.full), 32'd0);
        chk("async rd_data0", 32'(bus0.rd_data), 32'd0);
        chk("async rd_data1", 32'(bus1.rd_data), 32'd0);
        chk("async ovf", 32'(bus0.overflow), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        chk("post-rst unf", 32'(bus0.underflow), 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 8'h5A);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        chk("post-rst data", 32'(bus0.rd_data), 32'h5A);
        chk("post-rst unf clr", 32'(bus0.underflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
